ex_muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide sequencer beside the execute-stage int_alu.

---
 rtl/ex_muldiv_seq.sv | 174 +++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide unit beside the execute stage: radix-2 shift-add
// multiply and restoring divide, one bit per cycle, with a one-cycle result window.
module ex_muldiv_seq #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_flush,
    input  logic            id_ex__md_valid,
    input  logic [2:0]      id_ex__md_op,
    input  logic [XLEN-1:0] id_ex__rs1_rdata,
    input  logic [XLEN-1:0] id_ex__rs2_rdata,
    output logic            md_stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                neg_q, neg_d;
    logic                a_neg_q, a_neg_d;
    logic                div0_q, div0_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand conditioning for the op being offered by id_ex
    logic            a_signed, b_signed, a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            in_div0, in_ovf;

    always_comb begin
        a_signed = (id_ex__md_op != 3'd3) && (id_ex__md_op[0] == 1'b0 || id_ex__md_op == 3'd1);
        b_signed = a_signed && (id_ex__md_op != 3'd2);
        a_neg_in = a_signed & id_ex__rs1_rdata[XLEN-1];
        b_neg_in = b_signed & id_ex__rs2_rdata[XLEN-1];
        a_abs    = a_neg_in ? -id_ex__rs1_rdata : id_ex__rs1_rdata;
        b_abs    = b_neg_in ? -id_ex__rs2_rdata : id_ex__rs2_rdata;
        in_div0  = (id_ex__rs2_rdata == '0);
        in_ovf   = ~id_ex__md_op[0] && (id_ex__rs1_rdata == MIN_NEG) && (id_ex__rs2_rdata == '1);
    end

    // One iteration of each algorithm; acc holds {high, low} of product or {remainder, dividend/quotient}
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, mul_signed;
    logic [XLEN:0]     div_shift, div_sub;
    logic              q_bit;
    logic [XLEN-1:0]   rem_new, quo_fin, rem_fin;
    logic [2*XLEN-1:0] div_step;

    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step   = {mul_sum, acc_q[XLEN-1:1]};
        mul_signed = neg_q ? -mul_step : mul_step;

        div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_sub    = div_shift - {1'b0, opb_q};
        q_bit      = ~div_sub[XLEN];
        rem_new    = q_bit ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
        div_step   = {rem_new, acc_q[XLEN-2:0], q_bit};

        // A zero divisor leaves |a| in the remainder, so only the quotient needs overriding
        quo_fin    = div0_q ? '1 : (neg_q ? -div_step[XLEN-1:0] : div_step[XLEN-1:0]);
        rem_fin    = a_neg_q ? -div_step[2*XLEN-1:XLEN] : div_step[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        div0_d   = div0_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (id_ex__md_valid) begin
                    op_d    = id_ex__md_op;
                    cnt_d   = '0;
                    opb_d   = b_abs;
                    neg_d   = a_neg_in ^ b_neg_in;
                    a_neg_d = a_neg_in;
                    div0_d  = in_div0;
                    acc_d   = {{XLEN{1'b0}}, a_abs};
                    if (!id_ex__md_op[2]) begin
                        acc_d   = {{XLEN{1'b0}}, b_abs};
                        opb_d   = a_abs;
                        state_d = S_MUL;
                    end else if (FAST_SPECIAL && (in_div0 || in_ovf)) begin
                        if (id_ex__md_op[1])
                            result_d = in_div0 ? id_ex__rs1_rdata : '0;
                        else
                            result_d = in_div0 ? '1 : MIN_NEG;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d = (op_q == 3'd0) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d = op_q[1] ? rem_fin : quo_fin;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything, including a pending completion
        if (pipe_flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            div0_q   <= div0_d;
            result_q <= result_d;
        end
    end

    assign md_stall  = ~pipe_flush &
                       (((state_q == S_IDLE) & id_ex__md_valid) | (state_q == S_MUL) | (state_q == S_DIV));
    assign md_done   = (state_q == S_DONE);
    assign md_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: results, latency, stall length, flush, reset, back-to-back ops.
module tb_ex_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        pipe_flush;
    logic        id_ex__md_valid;
    logic [2:0]  id_ex__md_op;
    logic [31:0] id_ex__rs1_rdata;
    logic [31:0] id_ex__rs2_rdata;
    logic        md_stall;
    logic        md_done;
    logic [31:0] md_result;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipe_flush       (pipe_flush),
        .id_ex__md_valid  (id_ex__md_valid),
        .id_ex__md_op     (id_ex__md_op),
        .id_ex__rs1_rdata (id_ex__rs1_rdata),
        .id_ex__rs2_rdata (id_ex__rs2_rdata),
        .md_stall         (md_stall),
        .md_done          (md_done),
        .md_result        (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Offer one op, wait for md_done, check result, latency and stall-cycle count
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int stall_n;
        lat = 0;
        stall_n = 0;
        @(negedge clk);
        id_ex__md_valid  = 1'b1;
        id_ex__md_op     = op;
        id_ex__rs1_rdata = a;
        id_ex__rs2_rdata = b;
        #1;
        while (1) begin
            if (md_stall) stall_n++;
            @(posedge clk);
            #1;
            id_ex__md_valid = 1'b0;
            lat++;
            if (md_done || lat > 100) break;
        end
        chk({tag, " result"}, md_result, exp);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " stall cycles"}, 32'(stall_n), 32'(exp_lat));
        chk({tag, " stall in done"}, {31'd0, md_stall}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " done one cycle"}, {31'd0, md_done}, 32'd0);
    endtask

    initial begin
        int lat;
        bit done_seen;
        rst = 1'b1;
        pipe_flush = 1'b0;
        id_ex__md_valid = 1'b0;
        id_ex__md_op = 3'd0;
        id_ex__rs1_rdata = '0;
        id_ex__rs2_rdata = '0;
        #1;
        chk("rst stall", {31'd0, md_stall}, 32'd0);
        chk("rst done", {31'd0, md_done}, 32'd0);
        chk("rst result", md_result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("MUL 7*6",        3'd0, 32'd7,        32'd6,        32'd42,       33);
        run_op("MUL -3*5",       3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33);
        run_op("MULH -1*-1",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("MULHU",          3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("MULHSU -1*2",    3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        run_op("DIV -7/2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("REM -7/2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("DIVU 100/7",     3'd5, 32'd100,      32'd7,        32'd14,       33);
        run_op("REMU 100/7",     3'd7, 32'd100,      32'd7,        32'd2,        33);
        run_op("DIV 5/0",        3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("REM 5/0",        3'd6, 32'd5,        32'd0,        32'd5,        1);
        run_op("DIVU 5/0",       3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("REM -5/0",       3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1);
        run_op("DIV ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_op("DIVU min/-1",    3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);

        // Flush a DIVU at iteration 10
        @(negedge clk);
        id_ex__md_valid = 1'b1;
        id_ex__md_op = 3'd5;
        id_ex__rs1_rdata = 32'd1000;
        id_ex__rs2_rdata = 32'd3;
        @(posedge clk);
        #1;
        id_ex__md_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("flush pre stall", {31'd0, md_stall}, 32'd1);
        pipe_flush = 1'b1;
        #1;
        chk("flush stall drop", {31'd0, md_stall}, 32'd0);
        @(posedge clk);
        #1;
        pipe_flush = 1'b0;
        #1;
        chk("flush idle stall", {31'd0, md_stall}, 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (md_done) done_seen = 1'b1;
        end
        chk("flush no done", {31'd0, done_seen}, 32'd0);
        run_op("MUL 3*3 post flush", 3'd0, 32'd3, 32'd3, 32'd9, 33);

        // Async reset mid-MUL
        @(negedge clk);
        id_ex__md_valid = 1'b1;
        id_ex__md_op = 3'd0;
        id_ex__rs1_rdata = 32'd5;
        id_ex__rs2_rdata = 32'd5;
        @(posedge clk);
        #1;
        id_ex__md_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst stall", {31'd0, md_stall}, 32'd0);
        chk("midrst done", {31'd0, md_done}, 32'd0);
        chk("midrst result", md_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back DIVU then REMU with valid held
        @(negedge clk);
        id_ex__md_valid = 1'b1;
        id_ex__md_op = 3'd5;
        id_ex__rs1_rdata = 32'd9;
        id_ex__rs2_rdata = 32'd4;
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (md_done || lat > 100) break;
        end
        chk("b2b DIVU result", md_result, 32'd2);
        chk("b2b DIVU latency", 32'(lat), 32'd33);
        id_ex__md_op = 3'd7;
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (md_done || lat > 100) break;
        end
        chk("b2b REMU result", md_result, 32'd1);
        chk("b2b REMU latency", 32'(lat), 32'd34);
        id_ex__md_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
